adder_checker: RTL and testbench

Self-checking harness block that drives the three adder inputs (DataA, DataB, Cin) through all 8 combinations and compares both adder implementations' outputs (Sum1/Cout1 and Sum2/Cout2) against a golden A+B+Cin. It sits on the other side of the adder pair's interface: it is the stimulus source and checker for the adders' ports. It reports per-implementation mismatch counts, the first failing vector, and a pass flag. It is the on-chip self-test for the adder comparison design.

---
 rtl/adder_checker.sv | 140 ++++++++++++++
 tb/tb_adder_checker.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_checker.sv
// On-chip self-test for a pair of 1-bit full adders: sweeps all 8 input
// vectors, checks both implementations against a golden sum, reports results.
module adder_checker #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       Start,
  output logic       DataA,
  output logic       DataB,
  output logic       Cin,
  input  logic       Sum1,
  input  logic       Cout1,
  input  logic       Sum2,
  input  logic       Cout2,
  output logic       Busy,
  output logic       Done,
  output logic       Pass,
  output logic [3:0] ErrCnt1,
  output logic [3:0] ErrCnt2,
  output logic       FirstErrValid,
  output logic [2:0] FirstErrVec
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] LP_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_vec;
  logic [3:0] r_settle;
  logic [3:0] r_err1;
  logic [3:0] r_err2;
  logic       r_first_valid;
  logic [2:0] r_first_vec;
  logic       r_pass;

  logic [1:0] w_gold;
  logic       w_mis1;
  logic       w_mis2;
  logic [3:0] w_err1_nxt;
  logic [3:0] w_err2_nxt;
  logic       w_settled;
  logic       w_last;
  logic       w_busy;

  assign w_gold     = {1'b0, r_vec[2]} + {1'b0, r_vec[1]} + {1'b0, r_vec[0]};
  assign w_mis1     = ({Cout1, Sum1} != w_gold);
  assign w_mis2     = ({Cout2, Sum2} != w_gold);
  assign w_err1_nxt = r_err1 + {3'b000, w_mis1};
  assign w_err2_nxt = r_err2 + {3'b000, w_mis2};
  assign w_settled  = (r_settle == LP_SETTLE_LAST);
  assign w_last     = (r_vec == 3'd7);

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (Start) w_state_nxt = S_APPLY;
      S_APPLY: if (w_settled) w_state_nxt = S_CHECK;
      S_CHECK: w_state_nxt = w_last ? S_DONE : S_APPLY;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pass is computed from the post-update counts so it is already valid
  // in the Done cycle rather than one cycle later.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_vec         <= '0;
      r_settle      <= '0;
      r_err1        <= '0;
      r_err2        <= '0;
      r_first_valid <= 1'b0;
      r_first_vec   <= '0;
      r_pass        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_vec         <= '0;
            r_settle      <= '0;
            r_err1        <= '0;
            r_err2        <= '0;
            r_first_valid <= 1'b0;
            r_first_vec   <= '0;
            r_pass        <= 1'b0;
          end
        end
        S_APPLY: begin
          r_settle <= w_settled ? '0 : r_settle + 4'd1;
        end
        S_CHECK: begin
          r_err1 <= w_err1_nxt;
          r_err2 <= w_err2_nxt;
          if ((w_mis1 || w_mis2) && !r_first_valid) begin
            r_first_valid <= 1'b1;
            r_first_vec   <= r_vec;
          end
          if (w_last) begin
            r_pass <= (w_err1_nxt == 4'd0) && (w_err2_nxt == 4'd0);
          end else begin
            r_vec <= r_vec + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_busy = (r_state == S_APPLY) || (r_state == S_CHECK);
    Busy   = w_busy;
    Done   = (r_state == S_DONE);
    DataA  = w_busy & r_vec[2];
    DataB  = w_busy & r_vec[1];
    Cin    = w_busy & r_vec[0];
  end

  assign Pass          = r_pass;
  assign ErrCnt1       = r_err1;
  assign ErrCnt2       = r_err2;
  assign FirstErrValid = r_first_valid;
  assign FirstErrVec   = r_first_vec;

endmodule

// File: tb/tb_adder_checker.sv
// Directed bench for adder_checker: behavioural adder models with fault
// modes, a table of sweep outcomes, and hand-written timing/reset sequences.
module tb_adder_checker;

  logic       clk;
  logic       rstn;

  logic       start_a, da_a, db_a, ci_a, s1_a, c1_a, s2_a, c2_a;
  logic       busy_a, done_a, pass_a, fv_a;
  logic [3:0] e1_a, e2_a;
  logic [2:0] fvec_a;

  logic       start_b, da_b, db_b, ci_b, s1_b, c1_b, s2_b, c2_b;
  logic       busy_b, done_b, pass_b, fv_b;
  logic [3:0] e1_b, e2_b;
  logic [2:0] fvec_b;

  int         mode_a;
  logic       corrupt_b;
  int         n_checks;
  int         n_errors;

  adder_checker u_dut_a (
    .CLK(clk), .RESETn(rstn), .Start(start_a),
    .DataA(da_a), .DataB(db_a), .Cin(ci_a),
    .Sum1(s1_a), .Cout1(c1_a), .Sum2(s2_a), .Cout2(c2_a),
    .Busy(busy_a), .Done(done_a), .Pass(pass_a),
    .ErrCnt1(e1_a), .ErrCnt2(e2_a),
    .FirstErrValid(fv_a), .FirstErrVec(fvec_a)
  );

  adder_checker #(.SETTLE_CYCLES(3)) u_dut_b (
    .CLK(clk), .RESETn(rstn), .Start(start_b),
    .DataA(da_b), .DataB(db_b), .Cin(ci_b),
    .Sum1(s1_b), .Cout1(c1_b), .Sum2(s2_b), .Cout2(c2_b),
    .Busy(busy_b), .Done(done_b), .Pass(pass_b),
    .ErrCnt1(e1_b), .ErrCnt2(e2_b),
    .FirstErrValid(fv_b), .FirstErrVec(fvec_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder models for DUT A; mode selects an injected adder fault.
  always_comb begin
    logic [1:0] g;
    g    = {1'b0, da_a} + {1'b0, db_a} + {1'b0, ci_a};
    s1_a = g[0];
    c1_a = g[1];
    s2_a = g[0];
    c2_a = g[1];
    case (mode_a)
      1: s1_a = 1'b0;
      2: c2_a = ~g[1];
      3: c1_a = 1'b1;
      4: begin c1_a = 1'b0; s2_a = 1'b1; end
      default: ;
    endcase
  end

  // Adder models for DUT B; corrupt_b inverts every adder output.
  always_comb begin
    logic [1:0] g;
    g    = {1'b0, da_b} + {1'b0, db_b} + {1'b0, ci_b};
    s1_b = g[0] ^ corrupt_b;
    c1_b = g[1] ^ corrupt_b;
    s2_b = g[0] ^ corrupt_b;
    c2_b = g[1] ^ corrupt_b;
  end

  typedef struct {
    string      name;
    int         mode;
    logic [3:0] e1;
    logic [3:0] e2;
    logic       fv;
    logic [2:0] fvec;
    logic       pass;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a sweep on DUT A from IDLE and returns at cycle 17 (Done cycle).
  task automatic run_sweep_a(input string tag, input bit hold, input int pulse_at);
    int done_cyc;
    int busy_bad;
    done_cyc = -1;
    busy_bad = 0;
    start_a  = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      start_a = hold || (c == pulse_at);
      if (busy_a !== (c <= 16)) busy_bad++;
      if (done_a === 1'b1) begin
        done_cyc = c;
        break;
      end
    end
    chk({tag, " done_cycle"}, done_cyc, 17);
    chk({tag, " busy_window"}, busy_bad, 0);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    mode_a    = 0;
    corrupt_b = 1'b0;
    start_a   = 1'b0;
    start_b   = 1'b0;
    rstn      = 1'b0;

    tbl[0] = '{"good",      0, 4'd0, 4'd0, 1'b0, 3'b000, 1'b1};
    tbl[1] = '{"sum1_zero", 1, 4'd4, 4'd0, 1'b1, 3'b001, 1'b0};
    tbl[2] = '{"cout2_inv", 2, 4'd0, 4'd8, 1'b1, 3'b000, 1'b0};
    tbl[3] = '{"regood",    0, 4'd0, 4'd0, 1'b0, 3'b000, 1'b1};
    tbl[4] = '{"cout1_one", 3, 4'd4, 4'd0, 1'b1, 3'b000, 1'b0};
    tbl[5] = '{"mixed",     4, 4'd4, 4'd4, 1'b1, 3'b000, 1'b0};

    tick();
    tick();
    chk("reset_a", {da_a, db_a, ci_a, busy_a, done_a, pass_a, e1_a, e2_a, fv_a, fvec_a}, 0);
    chk("reset_b", {da_b, db_b, ci_b, busy_b, done_b, pass_b, e1_b, e2_b, fv_b, fvec_b}, 0);
    rstn = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      mode_a = tbl[i].mode;
      run_sweep_a(tbl[i].name, 1'b0, 0);
      chk({tbl[i].name, " errcnt1"}, e1_a, tbl[i].e1);
      chk({tbl[i].name, " errcnt2"}, e2_a, tbl[i].e2);
      chk({tbl[i].name, " first_valid"}, fv_a, tbl[i].fv);
      if (tbl[i].fv) chk({tbl[i].name, " first_vec"}, fvec_a, tbl[i].fvec);
      chk({tbl[i].name, " pass"}, pass_a, tbl[i].pass);
      tick();
      chk({tbl[i].name, " held"}, {done_a, busy_a, pass_a, e1_a, e2_a},
          {1'b0, 1'b0, tbl[i].pass, tbl[i].e1, tbl[i].e2});
    end
    mode_a = 0;

    // Start held high: one sweep, IDLE for a cycle, then a second sweep.
    begin
      int done2;
      run_sweep_a("hold", 1'b1, 0);
      tick();
      chk("hold idle_gap", busy_a, 0);
      tick();
      start_a = 1'b0;
      chk("hold restart", {busy_a, da_a, db_a, ci_a}, 4'b1000);
      done2 = -1;
      for (int c = 20; c <= 60; c++) begin
        tick();
        if (done_a === 1'b1) begin
          done2 = c;
          break;
        end
      end
      chk("hold second_done", done2, 35);
      tick();
    end

    // Start pulse in cycle 6 is ignored.
    run_sweep_a("pulse", 1'b0, 6);
    tick();
    chk("pulse idle18", busy_a, 0);
    tick();
    chk("pulse idle19", busy_a, 0);

    // Reset in cycle 5 aborts the sweep.
    begin
      int saw_done;
      mode_a  = 1;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      for (int c = 2; c <= 5; c++) tick();
      rstn = 1'b0;
      tick();
      chk("abort outputs", {da_a, db_a, ci_a, busy_a, done_a, pass_a, e1_a, e2_a, fv_a, fvec_a}, 0);
      rstn     = 1'b1;
      saw_done = 0;
      for (int c = 0; c < 25; c++) begin
        tick();
        if (done_a === 1'b1 || busy_a === 1'b1) saw_done++;
      end
      chk("abort no_done", saw_done, 0);
      mode_a = 0;
      run_sweep_a("after_abort", 1'b0, 0);
      chk("after_abort result", {pass_a, e1_a, e2_a, fv_a}, {1'b1, 4'd0, 4'd0, 1'b0});
      tick();
    end

    // SETTLE_CYCLES=3: corruption only in APPLY must pass, only in CHECK must fail.
    for (int pass_no = 0; pass_no < 2; pass_no++) begin
      int done_cyc;
      done_cyc = -1;
      start_b  = 1'b1;
      for (int c = 1; c <= 50; c++) begin
        tick();
        start_b   = 1'b0;
        corrupt_b = (c <= 32) && ((((c - 1) % 4) == 3) == (pass_no == 1));
        if (done_b === 1'b1) begin
          done_cyc = c;
          break;
        end
      end
      corrupt_b = 1'b0;
      if (pass_no == 0) begin
        chk("s3_apply done_cycle", done_cyc, 33);
        chk("s3_apply result", {pass_b, e1_b, e2_b, fv_b}, {1'b1, 4'd0, 4'd0, 1'b0});
      end else begin
        chk("s3_check done_cycle", done_cyc, 33);
        chk("s3_check result", {pass_b, e1_b, e2_b, fv_b, fvec_b},
            {1'b0, 4'd8, 4'd8, 1'b1, 3'b000});
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
